// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional message locking is compiled in with `define UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      err_timeout,
  output logic [1:0]                dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_SAT  = TMR_W'(BUSY_TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_oh;

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q, lock_d;

  // While locked, win_q still holds the message owner: only it can win.
  always_comb begin
    cand = req_valid;
    if (lock_q) cand = req_valid & (ONE << win_q);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_comb cand = req_valid;
`endif

  // Rotating search starting one past the last completed owner.
  always_comb begin
    int pos;
    pos       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && cand[pos[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[IDX_W-1:0];
      end
    end
  end

  assign win_oh = ONE << win_idx;

  // Handshake: a byte moves when req_valid[i] & req_ready[i]; req_ready is one-hot,
  // raised only in IDLE for the winner, and held low while rst is asserted.
  assign req_ready = (rst && (state_q == S_IDLE) && win_found) ? win_oh : '0;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    grant_d    = grant_q;
    err_d      = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          tx_data_d  = req_data[int'(win_idx)*DATA_W +: DATA_W];
          tx_start_d = 1'b1;
          grant_d    = win_oh;
          win_d      = win_idx;
          timer_d    = '0;
          state_d    = S_WAIT_BUSY;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d     = !req_last[win_idx];
`endif
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else if (timer_q != TMR_SAT) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          grant_d = '0;
          state_d = S_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          if (!lock_q) ptr_d = win_q;
`else
          ptr_d   = win_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_RST;
      win_q      <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant       = grant_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one UART transmitter (`Tx`, driven by the `Baud_Rate_Generator` tick) among NUM_REQ byte producers. It grants one requester at a time and accepts one byte from it. It issues a single-cycle start pulse to the transmitter, then tracks the transmitter's Busy flag until the frame is complete. It sits between on-chip byte sources (e.g. an Rx echo path, status reporters) and the `Tx` instance in the top-level FPGA wrapper.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width; must match `Tx` data width.
- BUSY_TIMEOUT, 16: cycles to wait for `tx_busy` to rise after a start pulse before abandoning the byte.

Ports (clock and reset first):
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is the last of a message (used only with lock feature).
- req_ready  out  NUM_REQ  one-hot accept strobe; byte taken when req_valid[i] & req_ready[i].
- tx_data  out  DATA_W  byte to transmitter (`TxD_data`), registered.
- tx_start  out  1  one-cycle start pulse (`TxD_start`), registered.
- tx_busy  in  1  transmitter `Busy`.
- grant  out  NUM_REQ  one-hot owner of the byte in flight, registered; 0 when idle.
- err_timeout  out  1  one-cycle pulse when `tx_busy` never rose.

## Operation
- Reset values: req_ready=0, tx_data=0, tx_start=0, grant=0, err_timeout=0, state=IDLE, ptr=NUM_REQ-1, lock=0.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: candidate set = req_valid, masked to the lock owner when locked. The winner is the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap. req_ready = onehot(winner) combinationally, only in IDLE and only if the candidate set is non-empty.
- On acceptance: tx_data<=req_data[winner], tx_start<=1, grant<=onehot(winner), timer<=0, then go to WAIT_BUSY.
- WAIT_BUSY: tx_start cleared after one cycle. If tx_busy=1, go to WAIT_DONE. Otherwise timer increments; when timer reaches BUSY_TIMEOUT-1 with tx_busy still 0, pulse err_timeout, clear grant, clear lock, leave ptr unchanged, and go to IDLE.
- WAIT_DONE: when tx_busy=0, ptr<=winner index, grant<=0, go to IDLE.
- Requesters not granted see req_ready=0 and must hold req_valid/req_data stable.
- A requester dropping req_valid while not granted is legal. Dropping it after acceptance has no effect on the byte in flight.
- The timer is $clog2(BUSY_TIMEOUT+1) bits wide and saturates; it does not wrap.

## Timing
- Cycle t: IDLE, req_valid[i]=1 and i wins, so req_ready[i]=1.
- Cycle t+1: tx_start=1, tx_data valid, grant[i]=1.
- Cycle t+2: tx_start=0.
- Best case, the next acceptance is one cycle after tx_busy is sampled low in WAIT_DONE.
- Throughput: one byte per UART frame plus 3 cycles of overhead.
- Simultaneous requests are resolved strictly by rotating priority. No requester waits more than NUM_REQ-1 bytes (or messages, with lock).
- Reset asserted mid-frame clears all outputs asynchronously. The transmitter may finish its frame, but the arbiter then starts in IDLE with ptr=NUM_REQ-1.

## Configuration
- UART_TX_ARB_LOCK_EN defined: message locking is enabled.
  - If the accepted byte has req_last=0, lock<=1 with owner=winner, and IDLE considers only the owner until a byte with req_last=1 is accepted.
  - ptr updates only when the lock is released.
  - A timeout clears the lock.
- UART_TX_ARB_LOCK_EN undefined: req_last is ignored, arbitration is per byte, and the lock register is not implemented.

## Test plan
- Single request: req_valid=4'b0001, data 8'h41. Expect req_ready[0] for 1 cycle, tx_start 1 cycle later with tx_data=8'h41, grant=4'b0001 until tx_busy falls.
- All four valid continuously, data 8'h10+i. Expect bytes transmitted in order 10,11,12,13,10; each tx_start follows the previous busy-fall.
- Busy stuck at 0 (`Tx` model disabled), one request. Expect err_timeout pulse exactly BUSY_TIMEOUT cycles after tx_start, grant=0, then same requester re-granted (ptr unchanged).
- With UART_TX_ARB_LOCK_EN: req 1 sends 3 bytes, last=1 on the third, while req 0 and 2 are valid. Expect three consecutive req-1 bytes, then req 2 next.
- Without the macro, same stimulus: expect bytes from 1,2,0,1,… interleaved.
- Assert rst during WAIT_DONE. Expect tx_start, grant and req_ready at 0 immediately. After release, with req 0 and 3 valid, requester 0 wins first.
